// File: rtl/div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer. Runs restoring division one
// step per granted cycle on the shared datapath ALU; it has no subtractor of its own.
module div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_cntrl,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_ltu
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [3:0]       ALU_SUB   = 4'h8;

  state_t            state;
  logic              rem_q;
  logic              sign_q;
  logic              sign_r;
  logic [XLEN-1:0]   q_q;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   dvs_q;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   dvd_abs_in;
  logic [XLEN-1:0]   dvs_abs_in;
  logic              take;
  logic [XLEN-1:0]   r_nx;
  logic [XLEN-1:0]   q_nx;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   dvd_orig;

  assign dvd_abs_in = (~op[0] & dividend[XLEN-1]) ? -dividend : dividend;
  assign dvs_abs_in = (~op[0] & divisor[XLEN-1])  ? -divisor  : divisor;

  // R[31] set means the shifted partial remainder is >= 2^32, so it always
  // exceeds the divisor even though the 32-bit ALU compare cannot see that bit.
  assign take = r_q[XLEN-1] | ~alu_ltu;
  assign r_nx = take ? alu_out : alu_a;
  assign q_nx = {q_q[XLEN-2:0], take};

  assign q_fix = sign_q ? -q_q : q_q;
  assign r_fix = sign_r ? -r_q : r_q;
  // q_q still holds |dividend| in PREP; sign_r restores the original value.
  assign dvd_orig = sign_r ? -q_q : q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      alu_req   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cntrl <= '0;
      rem_q     <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dvs_q     <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (kill && state != S_IDLE) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        alu_req   <= 1'b0;
        alu_a     <= '0;
        alu_b     <= '0;
        alu_cntrl <= '0;
      end else begin
        case (state)
          S_IDLE: if (start && !kill) begin
            rem_q  <= op[1];
            sign_q <= ~op[0] & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            sign_r <= ~op[0] & dividend[XLEN-1];
            q_q    <= dvd_abs_in;
            r_q    <= '0;
            dvs_q  <= dvs_abs_in;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_PREP;
          end
          S_PREP: begin
            if (dvs_q == '0) begin
              result <= rem_q ? dvd_orig : '1;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              alu_req   <= 1'b1;
              alu_cntrl <= ALU_SUB;
              alu_a     <= {r_q[XLEN-2:0], q_q[XLEN-1]};
              alu_b     <= dvs_q;
              cnt       <= '0;
              state     <= S_ITER;
            end
          end
          S_ITER: if (alu_gnt) begin
            r_q <= r_nx;
            q_q <= q_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              alu_req   <= 1'b0;
              alu_a     <= '0;
              alu_b     <= '0;
              alu_cntrl <= '0;
              state     <= S_FIX;
            end else begin
              alu_a <= {r_nx[XLEN-2:0], q_nx[XLEN-1]};
            end
          end
          S_FIX: begin
            q_q    <= q_fix;
            r_q    <= r_fix;
            result <= rem_q ? r_fix : q_fix;
            done   <= 1'b1;
            state  <= S_DONE;
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a behavioural ALU beside the DUT, hand-computed
// quotients/remainders, latency, stall, kill, reset and back-to-back checks.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, alu_req, alu_ltu;
  logic        alu_gnt = 1'b1;
  logic [31:0] result, alu_a, alu_b, alu_out;
  logic [3:0]  alu_cntrl;

  bit          gnt_rand = 1'b0;
  int          stalls = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] a_sav = '0, b_sav = '0;
  int          checks = 0, passes = 0, fails = 0;

  div_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .kill(kill),
    .busy(busy), .done(done), .result(result),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cntrl(alu_cntrl), .alu_out(alu_out), .alu_ltu(alu_ltu)
  );

  assign alu_out = alu_a - alu_b;
  assign alu_ltu = alu_a < alu_b;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Grant driver: operands must not move across an ungranted ITER edge.
  always @(negedge clk) begin
    if (stall_prev) begin
      check("alu_a_hold", alu_a, a_sav);
      check("alu_b_hold", alu_b, b_sav);
    end
    alu_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    stall_prev = alu_req && !alu_gnt;
    if (stall_prev) begin
      stalls++;
      a_sav = alu_a;
      b_sav = alu_b;
    end
  end

  // exp_lat of 0 means 35 plus the stalled ITER cycles.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b; stalls = 0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_res"}, result, exp);
    check({tag, "_lat"}, 32'(n), 32'((exp_lat == 0) ? 35 + stalls : exp_lat));
    @(negedge clk);
    check({tag, "_end"}, {30'b0, done, busy}, 32'h0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check({tag, "_done"}, {31'b0, done}, 32'h0);
    check({tag, "_req"}, {31'b0, alu_req}, 32'h0);
    check({tag, "_cntrl"}, {28'b0, alu_cntrl}, 32'h0);
    check({tag, "_a"}, alu_a, 32'h0);
    check({tag, "_b"}, alu_b, 32'h0);
    check({tag, "_result"}, result, 32'h0);
  endtask

  initial begin
    int n;
    logic seen_done;

    #1;
    check_zero_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    run_op("divu_100_7",   2'b01, 32'd100,       32'd7,         32'd14,        35);
    run_op("remu_100_7",   2'b11, 32'd100,       32'd7,         32'd2,         35);
    run_op("div_m100_7",   2'b00, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  35);
    run_op("rem_m100_7",   2'b10, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  35);
    run_op("rem_100_m7",   2'b10, 32'd100,       32'hFFFFFFF9,  32'd2,         35);
    run_op("div_ovf",      2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  35);
    run_op("rem_ovf",      2'b10, 32'h80000000,  32'hFFFFFFFF,  32'h0,         35);
    run_op("divu_5_0",     2'b01, 32'd5,         32'd0,         32'hFFFFFFFF,  2);
    run_op("rem_m5_0",     2'b10, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  2);
    run_op("divu_big",     2'b01, 32'hFFFFFFFF,  32'h80000001,  32'h1,         35);
    run_op("remu_big",     2'b11, 32'hFFFFFFFF,  32'h80000001,  32'h7FFFFFFE,  35);

    gnt_rand = 1'b1;
    run_op("divu_big_rg",  2'b01, 32'hFFFFFFFF,  32'h80000001,  32'h1,         0);
    run_op("remu_big_rg",  2'b11, 32'hFFFFFFFF,  32'h80000001,  32'h7FFFFFFE,  0);
    run_op("div_m100_rg",  2'b00, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  0);
    gnt_rand = 1'b0;

    // Kill partway through ITER: prior result (0xFFFFFFF2) must survive.
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 11; i++) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'h0);
    check("kill_req", {31'b0, alu_req}, 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    check("kill_no_done", {31'b0, seen_done}, 32'h0);
    check("kill_result", result, 32'hFFFFFFF2);

    // Asynchronous reset mid-ITER clears outputs without waiting for an edge.
    @(negedge clk);
    start = 1'b1; op = 2'b11; dividend = 32'hFFFFFFFF; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 15; i++) @(negedge clk);
    check("mid_iter_req", {31'b0, alu_req}, 32'h1);
    reset = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    run_op("after_rst",    2'b01, 32'd1000,      32'd10,        32'd100,       35);

    // start held high: second op launches from the one IDLE cycle after DONE.
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("held_res1", result, 32'd14);
    check("held_lat1", 32'(n), 32'd35);
    op = 2'b11;
    @(negedge clk);
    check("held_idle_gap", {31'b0, busy}, 32'h0);
    @(negedge clk);
    check("held_restart", {31'b0, busy}, 32'h1);
    n = 1;
    start = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      start = (n >= 5 && n <= 8);
    end
    start = 1'b0;
    check("held_res2", result, 32'd2);
    check("held_lat2", 32'(n), 32'd35);
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen_done = seen_done | done | busy;
    end
    check("held_no_extra", {31'b0, seen_done}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle RV32M divide/remainder sequencer: DIV, DIVU, REM, REMU.
- Owns no subtractor. It borrows the shared datapath ALU, one restoring-division step per granted cycle.
- It requests the ALU through a req/gnt pair, drives the ALU operands and control, and reads back the ALU difference and its unsigned-borrow flag.
- Sits beside the execute stage. The pipeline stalls on busy and captures result on done.

Parameters:
- XLEN, 32: operand/result width. Only 32 is supported; it matches the ALU width.
- CNT_W, 6: step counter width; must hold 0..XLEN.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  launch request; sampled only in IDLE
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of 1xx)
- dividend  input  32  rs1 value, captured on accepted start
- divisor  input  32  rs2 value, captured on accepted start
- kill  input  1  synchronous abort (pipeline flush)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result valid
- result  output  32  quotient or remainder; held until the next accepted start
- alu_req  output  1  request for the shared ALU
- alu_gnt  input  1  ALU granted this cycle
- alu_a  output  32  ALU operand A
- alu_b  output  32  ALU operand B
- alu_cntrl  output  4  ALU op select
- alu_out  input  32  ALU result (A-B)
- alu_ltu  input  1  ALU unsigned less-than flag (br_flags[2]); 1 means A<B

Behaviour:
- Reset (async, reset=1): state IDLE. busy, done, alu_req, alu_a, alu_b, alu_cntrl, result and all internal registers go to 0.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE to PREP when start=1.
  - Capture op, dividend and divisor.
  - For signed ops (op[0]=0), capture the absolute values and record sign_q = dividend[31]^divisor[31] and sign_r = dividend[31].
  - abs(0x80000000) = 0x80000000, treated as unsigned.
- PREP:
  - If divisor==0, set Q=0xFFFFFFFF and R=original dividend, then go to DONE. The sign fix is skipped.
  - Otherwise load Q=|dividend|, R=0, cnt=0, and go to ITER.
- ITER: alu_req=1, alu_cntrl=4'h8 (sub), alu_a={R[30:0],Q[31]}, alu_b=|divisor|.
  - When alu_gnt=1:
    - If R[31]==1 or alu_ltu==0: R<=alu_out and Q<={Q[30:0],1}.
    - Else: R<=alu_a and Q<={Q[30:0],0}.
    - cnt<=cnt+1.
    - After the 32nd granted step, go to FIX.
  - When alu_gnt=0: no register changes and operands stay driven (stall).
- Outside ITER: alu_req=0, alu_a=0, alu_b=0, alu_cntrl=0.
- FIX:
  - Signed ops only: Q<=-Q if sign_q, R<=-R if sign_r (two's complement, internal negator).
  - Then go to DONE.
  - Overflow case 0x80000000 / 0xFFFFFFFF produces Q=0x80000000, R=0 with no special casing.
- DONE:
  - done=1 for exactly one cycle; result<=Q for op[1]=0, R for op[1]=1 (registered, visible in the DONE cycle).
  - Then go to IDLE.
- Latency with alu_gnt held high: start sampled at edge 0, PREP cycle 1, ITER cycles 2-33, FIX cycle 34, DONE (done=1) cycle 35.
  - Each gnt=0 cycle in ITER adds one cycle.
  - Divide by zero: done in cycle 2.
- start while busy: ignored. No queueing.
- kill=1 in any non-IDLE state: go to IDLE next edge. No done pulse; result unchanged.
- kill has priority over start in the same cycle.
- busy falls in the cycle after DONE. A start in that IDLE cycle is accepted, giving back-to-back operations with one IDLE cycle between them.

Test Plan:
- DIVU 100/7, gnt=1 -> done in cycle 35, result 14; REMU same operands -> result 2.
- DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2(-14); REM -> 0xFFFFFFFE(-2); REM 100/-7 -> 2.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. DIVU 5/0 -> 0xFFFFFFFF in cycle 2; REM -5/0 -> 0xFFFFFFFB.
- DIVU 0xFFFFFFFF/0x80000001 (shifted-R MSB path) -> Q=1, REMU -> 0x7FFFFFFE. Toggle alu_gnt 50% random -> same result; done delayed by the number of gnt=0 ITER cycles; alu_a/alu_b stable while gnt=0.
- kill at ITER step 10 -> IDLE next cycle, no done, result keeps prior value. Assert reset mid-ITER -> all outputs 0 immediately.
- start held high through an operation -> second op starts one cycle after DONE; start pulses while busy produce no extra done.
